// File: rtl/tlu_dut_rx.sv
// DUT-side TLU trigger receiver: detects a trigger, clocks in the serial trigger ID
// LSB first, and hands it to the readout over a valid/ready handshake.
module tlu_dut_rx #(
    parameter int CLK_DIV = 4,
    parameter int ID_BITS = 15,
    parameter int TIMEOUT = 255
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RST_N,
    input  logic               ENABLE,
    input  logic               TLU_TRIGGER,
    output logic               TLU_BUSY,
    output logic               TLU_CLOCK,
    output logic [ID_BITS-1:0] ID,
    output logic               ID_VALID,
    input  logic               ID_READY,
    output logic               ID_MISMATCH,
    output logic [7:0]         ERR_CNT
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(ID_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(ID_BITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REL,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_OUTPUT
    } state_e;

    state_e             state_q, state_d;
    logic               trig_meta_q, trig_meta_d;
    logic               trig_s_q, trig_s_d;
    logic               trig_d_q, trig_d_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [TW-1:0]      to_q, to_d;
    logic [ID_BITS-1:0] shift_q, shift_d;
    logic [ID_BITS-1:0] exp_q, exp_d;
    logic [7:0]         err_q, err_d;
    logic               busy_q, busy_d;
    logic               clk_q, clk_d;
    logic               valid_q, valid_d;
    logic               mm_q, mm_d;
    logic               rise;
    logic               phase_last;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        to_d        = to_q;
        shift_d     = shift_q;
        exp_d       = exp_q;
        err_d       = err_q;
        trig_meta_d = TLU_TRIGGER;
        trig_s_d    = trig_meta_q;
        trig_d_d    = trig_s_q;
        rise        = trig_s_q & ~trig_d_q;
        phase_last  = (phase_q == PH_LAST);

        case (state_q)
            S_IDLE: begin
                if (ENABLE && rise) begin
                    state_d = S_WAIT_REL;
                    to_d    = '0;
                end
            end
            S_WAIT_REL: begin
                if (!trig_s_q) begin
                    state_d = S_SETUP;
                    phase_d = '0;
                end else if (to_q == TO_LAST) begin
                    state_d = S_IDLE;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_SETUP: begin
                phase_d = phase_last ? '0 : phase_q + 1'b1;
                bit_d   = '0;
                if (phase_last) state_d = S_HIGH;
            end
            S_HIGH: begin
                phase_d = phase_last ? '0 : phase_q + 1'b1;
                if (phase_last) state_d = S_LOW;
            end
            S_LOW: begin
                phase_d = phase_last ? '0 : phase_q + 1'b1;
                // Sample late in the low phase so the transmitter's round trip has settled.
                if (phase_last) begin
                    shift_d = {trig_s_q, shift_q[ID_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? S_OUTPUT : S_HIGH;
                end
            end
            S_OUTPUT: begin
                if (ID_READY) begin
                    exp_d   = shift_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state change.
        busy_d  = (state_d != S_IDLE);
        clk_d   = (state_d == S_HIGH);
        valid_d = (state_d == S_OUTPUT);
        mm_d    = (state_d == S_OUTPUT) && (shift_d != exp_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state_q     <= S_IDLE;
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_d_q    <= 1'b0;
            phase_q     <= '0;
            bit_q       <= '0;
            to_q        <= '0;
            shift_q     <= '0;
            exp_q       <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            clk_q       <= 1'b0;
            valid_q     <= 1'b0;
            mm_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_meta_q <= trig_meta_d;
            trig_s_q    <= trig_s_d;
            trig_d_q    <= trig_d_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            to_q        <= to_d;
            shift_q     <= shift_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            clk_q       <= clk_d;
            valid_q     <= valid_d;
            mm_q        <= mm_d;
        end
    end

    assign TLU_BUSY    = busy_q;
    assign TLU_CLOCK   = clk_q;
    assign ID          = shift_q;
    assign ID_VALID    = valid_q;
    assign ID_MISMATCH = mm_q;
    assign ERR_CNT     = err_q;

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Self-checking bench for tlu_dut_rx: a transmitter bus-functional model drives the
// trigger line, and a small reference model tracks the expected ID and error count.
module tb_tlu_dut_rx;

    localparam int CLK_DIV = 4;
    localparam int ID_BITS = 15;
    localparam int TIMEOUT = 255;
    // Release of the trigger reaches SETUP after 3 edges (2 sync + decision), then the frame.
    localparam int VALID_LAT = 3 + CLK_DIV + 2 * CLK_DIV * ID_BITS;

    logic               SYS_CLK = 1'b0;
    logic               SYS_RST_N = 1'b0;
    logic               ENABLE = 1'b0;
    logic               TLU_TRIGGER = 1'b0;
    logic               TLU_BUSY;
    logic               TLU_CLOCK;
    logic [ID_BITS-1:0] ID;
    logic               ID_VALID;
    logic               ID_READY = 1'b0;
    logic               ID_MISMATCH;
    logic [7:0]         ERR_CNT;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [ID_BITS-1:0] exp_model = '0;
    int err_model = 0;

    typedef struct {
        logic [ID_BITS-1:0] id;
        logic               mm;
        int                 n_rise;
        int                 min_high;
        int                 max_high;
        int                 busy_lat;
        int                 valid_lat;
        bit                 ok;
    } tx_res_t;

    tlu_dut_rx #(.CLK_DIV(CLK_DIV), .ID_BITS(ID_BITS), .TIMEOUT(TIMEOUT)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N), .ENABLE(ENABLE),
        .TLU_TRIGGER(TLU_TRIGGER), .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
        .ID(ID), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
        .ID_MISMATCH(ID_MISMATCH), .ERR_CNT(ERR_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Transmitter model: raise the trigger, drop it on BUSY, then put bit i on the
    // line at the i-th rising TLU_CLOCK. Observes everything on negative edges.
    task automatic transact(input logic [ID_BITS-1:0] tx_id, input int stop_at_rise,
                            input bit drop_en, output tx_res_t r);
        int   high_run;
        int   bit_idx;
        logic prev_clk;
        r.id = '0; r.mm = 1'b0; r.n_rise = 0; r.min_high = 1000; r.max_high = 0;
        r.busy_lat = 0; r.valid_lat = 0; r.ok = 1'b0;
        TLU_TRIGGER = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) begin
                r.busy_lat = k;
                break;
            end
        end
        if (r.busy_lat == 0) begin
            TLU_TRIGGER = 1'b0;
            return;
        end
        TLU_TRIGGER = 1'b0;
        prev_clk = 1'b0;
        high_run = 0;
        bit_idx  = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge SYS_CLK);
            if (TLU_CLOCK && !prev_clk) begin
                r.n_rise++;
                if (drop_en && r.n_rise == 1) ENABLE = 1'b0;
                if (bit_idx < ID_BITS) TLU_TRIGGER = tx_id[bit_idx];
                bit_idx++;
            end
            if (TLU_CLOCK) begin
                high_run++;
            end else if (prev_clk) begin
                if (high_run < r.min_high) r.min_high = high_run;
                if (high_run > r.max_high) r.max_high = high_run;
                high_run = 0;
            end
            prev_clk = TLU_CLOCK;
            if (stop_at_rise > 0 && r.n_rise == stop_at_rise) begin
                r.ok = 1'b1;
                return;
            end
            if (ID_VALID) begin
                r.valid_lat = k;
                r.id = ID;
                r.mm = ID_MISMATCH;
                r.ok = 1'b1;
                break;
            end
        end
        TLU_TRIGGER = 1'b0;
    endtask

    task automatic do_accept(output logic v, output logic b);
        ID_READY = 1'b1;
        @(negedge SYS_CLK);
        v = ID_VALID;
        b = TLU_BUSY;
        ID_READY = 1'b0;
    endtask

    task automatic test_reset();
        SYS_RST_N = 1'b0; ENABLE = 1'b0; ID_READY = 1'b0; TLU_TRIGGER = 1'b0;
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        n_cmp++; if (TLU_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", TLU_BUSY); end
        n_cmp++; if (TLU_CLOCK !== 1'b0) begin n_fail++; $display("FAIL reset tlu_clock: got %b want 0", TLU_CLOCK); end
        n_cmp++; if (ID_VALID !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", ID_VALID); end
        n_cmp++; if (ID_MISMATCH !== 1'b0) begin n_fail++; $display("FAIL reset mismatch: got %b want 0", ID_MISMATCH); end
        n_cmp++; if (ID !== '0) begin n_fail++; $display("FAIL reset id: got %h want 0", ID); end
        n_cmp++; if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL reset err_cnt: got %0d want 0", ERR_CNT); end
        SYS_RST_N = 1'b1;
        ENABLE = 1'b1;
        exp_model = '0;
        err_model = 0;
        repeat (2) @(negedge SYS_CLK);
    endtask

    // Send one ID, compare ID and ID_MISMATCH against the model, then accept it.
    task automatic send_and_accept(input string tag, input logic [ID_BITS-1:0] tx_id, input bit drop_en);
        tx_res_t r;
        logic v, b;
        logic want_mm;
        want_mm = (tx_id != exp_model);
        transact(tx_id, 0, drop_en, r);
        n_cmp++; if (!r.ok) begin n_fail++; $display("FAIL %s completion: got no ID_VALID want ID_VALID", tag); end
        n_cmp++; if (r.id !== tx_id) begin n_fail++; $display("FAIL %s id: got %h want %h", tag, r.id, tx_id); end
        n_cmp++; if (r.mm !== want_mm) begin n_fail++; $display("FAIL %s mismatch: got %b want %b", tag, r.mm, want_mm); end
        do_accept(v, b);
        n_cmp++; if ({v, b} !== 2'b00) begin n_fail++; $display("FAIL %s handshake: got valid/busy %b%b want 00", tag, v, b); end
        exp_model = tx_id + 1'b1;
        repeat (4) @(negedge SYS_CLK);
    endtask

    task automatic test_id_sequence();
        logic [ID_BITS-1:0] ids [4];
        ids[0] = 15'd0; ids[1] = 15'd1; ids[2] = 15'd5; ids[3] = 15'd6;
        for (int i = 0; i < 4; i++) send_and_accept("id_seq", ids[i], 1'b0);
    endtask

    task automatic test_clocking();
        tx_res_t r;
        logic v, b;
        logic [ID_BITS-1:0] tx_id;
        logic want_mm;
        tx_id = ID_BITS'($urandom);
        want_mm = (tx_id != exp_model);
        transact(tx_id, 0, 1'b0, r);
        n_cmp++; if (r.n_rise != ID_BITS) begin n_fail++; $display("FAIL clk rises: got %0d want %0d", r.n_rise, ID_BITS); end
        n_cmp++; if (r.min_high != CLK_DIV || r.max_high != CLK_DIV) begin n_fail++; $display("FAIL clk high width: got %0d..%0d want %0d", r.min_high, r.max_high, CLK_DIV); end
        n_cmp++; if (r.busy_lat != 3) begin n_fail++; $display("FAIL busy latency: got %0d want 3", r.busy_lat); end
        n_cmp++; if (r.valid_lat != VALID_LAT) begin n_fail++; $display("FAIL valid latency: got %0d want %0d", r.valid_lat, VALID_LAT); end
        n_cmp++; if (r.id !== tx_id) begin n_fail++; $display("FAIL clocking id: got %h want %h", r.id, tx_id); end
        n_cmp++; if (r.mm !== want_mm) begin n_fail++; $display("FAIL clocking mismatch: got %b want %b", r.mm, want_mm); end
        do_accept(v, b);
        exp_model = tx_id + 1'b1;
        repeat (4) @(negedge SYS_CLK);
    endtask

    task automatic test_backpressure();
        tx_res_t r;
        logic v, b;
        logic [ID_BITS-1:0] tx_id;
        int unstable;
        tx_id = ID_BITS'($urandom);
        transact(tx_id, 0, 1'b0, r);
        n_cmp++; if (r.id !== tx_id) begin n_fail++; $display("FAIL bp id: got %h want %h", r.id, tx_id); end
        unstable = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge SYS_CLK);
            if (ID_VALID !== 1'b1 || TLU_BUSY !== 1'b1 || ID !== tx_id || ID_MISMATCH !== r.mm) unstable++;
        end
        n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL bp hold: got %0d unstable cycles want 0", unstable); end
        do_accept(v, b);
        n_cmp++; if ({v, b} !== 2'b00) begin n_fail++; $display("FAIL bp release: got valid/busy %b%b want 00", v, b); end
        exp_model = tx_id + 1'b1;
        repeat (4) @(negedge SYS_CLK);
    endtask

    task automatic test_wrap();
        send_and_accept("wrap_sync", 15'h7FFE, 1'b0);
        send_and_accept("wrap_7fff", 15'h7FFF, 1'b0);
        send_and_accept("wrap_0000", 15'h0000, 1'b0);
    endtask

    task automatic test_enable();
        int busy_seen;
        ENABLE = 1'b0;
        TLU_TRIGGER = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge SYS_CLK);
            if (k == 5) TLU_TRIGGER = 1'b0;
            if (TLU_BUSY) busy_seen++;
        end
        n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL enable gate: got %0d busy cycles want 0", busy_seen); end
        ENABLE = 1'b1;
        repeat (4) @(negedge SYS_CLK);
        send_and_accept("enable_drop", ID_BITS'($urandom), 1'b1);
        ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid();
        tx_res_t r;
        transact(ID_BITS'($urandom), 8, 1'b0, r);
        n_cmp++; if (!r.ok) begin n_fail++; $display("FAIL rst_mid reach bit 7: got %0d rises want 8", r.n_rise); end
        SYS_RST_N = 1'b0;
        @(negedge SYS_CLK);
        n_cmp++; if ({TLU_BUSY, TLU_CLOCK, ID_VALID, ID_MISMATCH} !== 4'b0000 || ID !== '0 || ERR_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got busy=%b clk=%b valid=%b mm=%b id=%h err=%0d want all 0",
                     TLU_BUSY, TLU_CLOCK, ID_VALID, ID_MISMATCH, ID, ERR_CNT);
        end
        TLU_TRIGGER = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        exp_model = '0;
        repeat (4) @(negedge SYS_CLK);
        send_and_accept("rst_mid fresh", ID_BITS'($urandom), 1'b0);
    endtask

    task automatic test_timeout();
        int busy_cnt;
        int bad;
        bit saw_valid, saw_clk, rose, fell;
        TLU_TRIGGER = 1'b1;
        busy_cnt = 0; saw_valid = 1'b0; saw_clk = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) busy_cnt++;
            if (ID_VALID) saw_valid = 1'b1;
            if (TLU_CLOCK) saw_clk = 1'b1;
        end
        TLU_TRIGGER = 1'b0;
        err_model = (err_model < 255) ? err_model + 1 : 255;
        n_cmp++; if (busy_cnt != TIMEOUT) begin n_fail++; $display("FAIL timeout busy cycles: got %0d want %0d", busy_cnt, TIMEOUT); end
        n_cmp++; if (int'(ERR_CNT) != err_model) begin n_fail++; $display("FAIL timeout err_cnt: got %0d want %0d", ERR_CNT, err_model); end
        n_cmp++; if (saw_valid || saw_clk) begin n_fail++; $display("FAIL timeout activity: got valid=%b clk=%b want 0 0", saw_valid, saw_clk); end
        repeat (4) @(negedge SYS_CLK);
        bad = 0;
        for (int i = 0; i < 259; i++) begin
            TLU_TRIGGER = 1'b1;
            rose = 1'b0; fell = 1'b0;
            for (int k = 0; k < TIMEOUT + 20; k++) begin
                @(negedge SYS_CLK);
                if (TLU_BUSY) rose = 1'b1;
                else if (rose) begin
                    fell = 1'b1;
                    break;
                end
            end
            TLU_TRIGGER = 1'b0;
            if (!fell) bad++;
            err_model = (err_model < 255) ? err_model + 1 : 255;
            repeat (4) @(negedge SYS_CLK);
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL timeout repeat: got %0d missing timeouts want 0", bad); end
        n_cmp++; if (int'(ERR_CNT) != err_model) begin n_fail++; $display("FAIL err_cnt saturate: got %0d want %0d", ERR_CNT, err_model); end
    endtask

    initial begin
        test_reset();
        test_id_sequence();
        test_clocking();
        test_backpressure();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
